// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - M-stage data-memory responder with wait states, byte-enable RAM, misalign detection (optional DMEM_FAST_READ_EN)
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  ByteEnM,
  output logic [31:0] ReadDataM,
  output logic        MemBusyM,
  output logic        MemDoneM,
  output logic        MisalignM
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int AW    = IDX_W + 2;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              we_q, we_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              misal_q, misal_d;

  logic [31:0]       mem [DEPTH_WORDS];
  logic              mem_we;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       rd_word_q;
  logic              cur_misal;

  // Only the index and byte-offset bits of the address matter; the rest wrap away.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{1'b0, AddrM[31:AW]};

  function automatic logic is_misaligned(input logic [1:0] off, input logic [3:0] be);
    return ((off != 2'b00) && (be == 4'b1111)) || off[0];
  endfunction

  assign idx_q     = addr_q[AW-1:2];
  assign rd_word_q = mem[idx_q];
  assign cur_misal = is_misaligned(addr_q[1:0], be_q);

`ifdef DMEM_FAST_READ_EN
  logic [IDX_W-1:0] idx_in;
  logic [31:0]      rd_word_in;
  assign idx_in     = AddrM[AW-1:2];
  assign rd_word_in = mem[idx_in];
`endif

  // Next-state, request latching and access decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    misal_d = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (MemReqM) begin
          addr_d  = AddrM[AW-1:0];
          wdata_d = WriteDataM;
          be_d    = ByteEnM;
          we_d    = MemWriteM;
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
`ifdef DMEM_FAST_READ_EN
          // Loads skip the wait states entirely and complete next cycle.
          if (!MemWriteM) begin
            cnt_d   = 4'd0;
            state_d = S_DONE;
            done_d  = 1'b1;
            misal_d = is_misaligned(AddrM[1:0], ByteEnM);
            rdata_d = misal_d ? 32'h0 : rd_word_in;
          end
`endif
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
          misal_d = cur_misal;
          if (we_q) begin
            mem_we = !cur_misal;
          end else begin
            rdata_d = cur_misal ? 32'h0 : rd_word_q;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      we_q    <= 1'b0;
      rdata_q <= 32'h0;
      done_q  <= 1'b0;
      misal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      misal_q <= misal_d;
    end
  end

  // RAM array, byte-lane writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  // Stall while a request is being taken or is waiting; released in DONE.
  always_comb begin
    MemBusyM = ((state_q == S_IDLE) && MemReqM) || (state_q == S_WAIT);
  end

  assign ReadDataM = rdata_q;
  assign MemDoneM  = done_q;
  assign MisalignM = misal_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int WS    = 2;
`ifdef DMEM_FAST_READ_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReqM, MemWriteM;
  logic [31:0] AddrM, WriteDataM;
  logic [3:0]  ByteEnM;
  logic [31:0] ReadDataM;
  logic        MemBusyM, MemDoneM, MisalignM;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] rdata_m;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .MemReqM(MemReqM), .MemWriteM(MemWriteM),
    .AddrM(AddrM), .WriteDataM(WriteDataM), .ByteEnM(ByteEnM),
    .ReadDataM(ReadDataM), .MemBusyM(MemBusyM), .MemDoneM(MemDoneM), .MisalignM(MisalignM)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_misal(input logic [31:0] a, input logic [3:0] be);
    return ((a[1:0] != 2'b00) && (be == 4'hF)) || a[0];
  endfunction

  // One full access, entered and left at a falling edge; request kept up through DONE.
  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int idx, lat, done_c, busy_n;
    bit mis;
    idx = int'((a >> 2) % DEPTH);
    mis = model_misal(a, be);
    lat = (FAST && !wr) ? 1 : WS + 1;
    if (wr) begin
      if (!mis)
        for (int i = 0; i < 4; i++)
          if (be[i]) mem_m[idx][8*i +: 8] = d[8*i +: 8];
    end else begin
      rdata_m = mis ? 32'h0 : mem_m[idx];
    end
    MemReqM = 1'b1; MemWriteM = wr; AddrM = a; WriteDataM = d; ByteEnM = be;
    #1;
    done_c = -1; busy_n = 0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin
        @(posedge clk); @(negedge clk);
        MemWriteM = 1'($urandom); AddrM = $urandom; WriteDataM = $urandom; ByteEnM = 4'($urandom);
        #1;
      end
      if (MemBusyM) busy_n++;
      if (MemDoneM) begin done_c = c; break; end
    end
    check_eq("done_cycle", 32'(done_c), 32'(lat));
    check_eq("busy_cycles", 32'(busy_n), 32'(lat));
    check_eq("misalign", {31'b0, MisalignM}, {31'b0, mis});
    check_eq("rdata_done", ReadDataM, rdata_m);
    MemReqM = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    check_eq("idle_busy", {31'b0, MemBusyM}, 32'h0);
    check_eq("idle_done", {31'b0, MemDoneM}, 32'h0);
    check_eq("rdata_hold", ReadDataM, rdata_m);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rdata"}, ReadDataM, 32'h0);
    check_eq({tag, "_busy"}, {31'b0, MemBusyM}, 32'h0);
    check_eq({tag, "_done"}, {31'b0, MemDoneM}, 32'h0);
    check_eq({tag, "_misal"}, {31'b0, MisalignM}, 32'h0);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  be;
    reset = 1'b0; MemReqM = 1'b0; MemWriteM = 1'b0; AddrM = '0; WriteDataM = '0; ByteEnM = '0;
    rdata_m = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1; #1;
    check_reset_outputs("reset");

    // Give every word a known value.
    for (int i = 0; i < DEPTH; i++) access(1'b1, 32'(i * 4), $urandom, 4'hF);

    access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    access(1'b0, 32'h10, 32'h0, 4'hF);
    check_eq("word_rd", ReadDataM, 32'hDEADBEEF);
    access(1'b1, 32'h10, 32'h000000AA, 4'b0001);
    access(1'b0, 32'h10, 32'h0, 4'hF);
    check_eq("byte_rd", ReadDataM, 32'hDEADBEAA);
    access(1'b0, 32'h12, 32'h0, 4'hF);
    access(1'b1, 32'h12, 32'h1, 4'hF);
    access(1'b0, 32'h10, 32'h0, 4'hF);
    check_eq("misal_store_supp", ReadDataM, 32'hDEADBEAA);
    access(1'b1, 32'h11, 32'hFFFFFFFF, 4'b0010);
    access(1'b1, 32'h10, 32'h12345678, 4'b0000);
    access(1'b1, 32'h100, 32'hCAFEF00D, 4'hF);
    access(1'b0, 32'h000, 32'h0, 4'hF);
    check_eq("wrap_rd", ReadDataM, 32'hCAFEF00D);

    // Reset while a store is waiting: RAM must keep its old word.
    MemReqM = 1'b1; MemWriteM = 1'b1; AddrM = 32'h20; WriteDataM = 32'h55; ByteEnM = 4'hF;
    @(posedge clk); @(negedge clk);
    reset = 1'b0; MemReqM = 1'b0; #1;
    check_reset_outputs("midreset");
    @(posedge clk); @(negedge clk);
    reset = 1'b1; rdata_m = 32'h0; #1;
    check_reset_outputs("postreset");
    access(1'b0, 32'h20, 32'h0, 4'hF);

    for (int n = 0; n < 150; n++) begin
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      d  = $urandom;
      be = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      access(1'($urandom), a, d, be);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
